axi4_ram_slave: RTL and testbench

AXI4_RAM_SLAVE -- requirements
Module: axi4_ram_slave

---
 rtl/axi4_ram_slave.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_axi4_ram_slave.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_ram_slave.sv
// ---------------------------------------------------------------------------
// axi4_ram_slave
//   AXI4 slave backed by an internal word-addressed RAM. The write path
//   (AW/W/B) and the read path (AR/R) are independent state machines and
//   may be active at the same time.
//
// Ports
//   aclk, areset        : clock, asynchronous active-high reset
//   axi_aw*             : write address channel (id, addr, len, size, burst)
//   axi_w*              : write data channel (data, strobes, last)
//   axi_b*              : write response channel (id, resp)
//   axi_ar*             : read address channel (id, addr, len, size, burst)
//   axi_r*              : read data channel (id, data, resp, last)
//
// Beats are always full width (size is ignored). Address bits above the
// RAM index alias onto the same words. WRAP bursts advance like INCR.
// ---------------------------------------------------------------------------
module axi4_ram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  aclk,
    input  logic                  areset,
    // AW channel
    input  logic [ID_WIDTH-1:0]   axi_awid,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    // W channel
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    input  logic [STRB_WIDTH-1:0] axi_wstrb,
    input  logic                  axi_wlast,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    // B channel
    output logic [ID_WIDTH-1:0]   axi_bid,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    // AR channel
    input  logic [ID_WIDTH-1:0]   axi_arid,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    // R channel
    output logic [ID_WIDTH-1:0]   axi_rid,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic                  axi_rvalid,
    input  logic                  axi_rready
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int DEPTH    = 1 << DEPTH_LOG2;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Next word index for a burst: FIXED holds, INCR and WRAP advance mod depth.
    function automatic logic [DEPTH_LOG2-1:0] next_idx(
        input logic [DEPTH_LOG2-1:0] idx,
        input logic [1:0]            burst
    );
        if (burst == BURST_FIXED) begin
            return idx;
        end else begin
            return idx + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // ---------------- write path state ----------------
    logic [1:0]            w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [DEPTH_LOG2-1:0] w_idx_q, w_idx_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic                  w_err_q, w_err_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic                  mem_we_s;
    logic                  w_beat_last_s;

    // ---------------- read path state ----------------
    logic [1:0]            r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [DEPTH_LOG2-1:0] r_idx_q, r_idx_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rlast_q, rlast_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;

    // Size fields and out-of-range address bits carry no meaning here.
    logic unused_s;
    assign unused_s = ^{axi_awsize, axi_arsize, axi_awaddr, axi_araddr};

    // Write FSM next-state: accept address, absorb exactly awlen+1 beats, respond.
    always_comb begin
        w_state_d     = w_state_q;
        w_id_d        = w_id_q;
        w_idx_d       = w_idx_q;
        w_len_d       = w_len_q;
        w_burst_d     = w_burst_q;
        w_cnt_d       = w_cnt_q;
        w_err_d       = w_err_q;
        bresp_d       = bresp_q;
        mem_we_s      = 1'b0;
        w_beat_last_s = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (axi_awvalid && awready_q) begin
                    w_id_d    = axi_awid;
                    w_idx_d   = axi_awaddr[ADDR_LSB+DEPTH_LOG2-1:ADDR_LSB];
                    w_len_d   = axi_awlen;
                    w_burst_d = axi_awburst;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (axi_wvalid && wready_q) begin
                    mem_we_s      = 1'b1;
                    w_beat_last_s = (w_cnt_q == w_len_q);
                    // A misplaced or missing wlast is flagged but the burst
                    // length is still governed by awlen alone.
                    if (axi_wlast != w_beat_last_s) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_err_d = w_err_q;
                    end
                    if (w_beat_last_s) begin
                        bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d   = w_cnt_q + 8'd1;
                        w_idx_d   = next_idx(w_idx_q, w_burst_q);
                        w_state_d = W_DATA;
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (axi_bready && bvalid_q) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
        // Handshake outputs are registered copies of the next state decode.
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Write FSM registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            w_id_q    <= {ID_WIDTH{1'b0}};
            w_idx_q   <= {DEPTH_LOG2{1'b0}};
            w_len_q   <= 8'd0;
            w_burst_q <= 2'b00;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
            bresp_q   <= 2'b00;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // RAM byte-lane write; contents are intentionally not reset.
    always_ff @(posedge aclk) begin
        if (mem_we_s) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (axi_wstrb[b]) begin
                    mem[w_idx_q][b*8 +: 8] <= axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM next-state: one fetch cycle per beat, then hold R until accepted.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: begin
                if (axi_arvalid && arready_q) begin
                    r_id_d    = axi_arid;
                    r_idx_d   = axi_araddr[ADDR_LSB+DEPTH_LOG2-1:ADDR_LSB];
                    r_len_d   = axi_arlen;
                    r_burst_d = axi_arburst;
                    r_cnt_d   = 8'd0;
                    r_state_d = R_FETCH;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_FETCH: begin
                // Sampled before any same-edge write lands: old data wins.
                rdata_d   = mem[r_idx_q];
                rlast_d   = (r_cnt_q == r_len_q);
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (axi_rready && rvalid_q) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d   = next_idx(r_idx_q, r_burst_q);
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_state_d = R_FETCH;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // Read FSM registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= {ID_WIDTH{1'b0}};
            r_idx_q   <= {DEPTH_LOG2{1'b0}};
            r_len_q   <= 8'd0;
            r_burst_q <= 2'b00;
            r_cnt_q   <= 8'd0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rlast_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            rdata_q   <= rdata_d;
            rlast_q   <= rlast_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bid     = w_id_q;
    assign axi_bresp   = bresp_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_arready = arready_q;
    assign axi_rid     = r_id_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = RESP_OKAY;
    assign axi_rlast   = rlast_q;
    assign axi_rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi4_ram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_ram_slave
//   Directed self-checking bench for axi4_ram_slave: reset values, single
//   and partial-strobe writes, INCR/FIXED bursts, R and B backpressure,
//   early wlast, and reset in the middle of a write burst.
// ---------------------------------------------------------------------------
module tb_axi4_ram_slave;

    logic        aclk;
    logic        areset;
    logic [7:0]  axi_awid;
    logic [15:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [7:0]  axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [7:0]  axi_arid;
    logic [15:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [7:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;

    int checks = 0;
    int errors = 0;

    axi4_ram_slave dut (
        .aclk        (aclk),
        .areset      (areset),
        .axi_awid    (axi_awid),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (axi_awsize),
        .axi_awburst (axi_awburst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bid     (axi_bid),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_arid    (axi_arid),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arsize  (axi_arsize),
        .axi_arburst (axi_arburst),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rid     (axi_rid),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Hard stop in case something unforeseen blocks the main sequence.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All outputs packed together; must be zero under reset.
    function automatic logic [63:0] all_outs();
        return {6'd0, axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid,
                axi_rlast, axi_bid, axi_bresp, axi_rid, axi_rdata, axi_rresp};
    endfunction

    task automatic aw_send(input logic [7:0] id, input logic [15:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n;
        @(negedge aclk);
        axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst;
        axi_awvalid = 1'b1;
        n = 0;
        while (axi_awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        chk("aw_wait", {63'd0, axi_awready}, 64'd1);
        @(posedge aclk);
        #1 axi_awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        @(negedge aclk);
        axi_wdata = data; axi_wstrb = strb; axi_wlast = last; axi_wvalid = 1'b1;
        n = 0;
        while (axi_wready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        chk("w_wait", {63'd0, axi_wready}, 64'd1);
        @(posedge aclk);
        #1 axi_wvalid = 1'b0;
    endtask

    task automatic b_recv(input logic [7:0] id, input logic [1:0] resp);
        int n;
        @(negedge aclk);
        axi_bready = 1'b1;
        n = 0;
        while (axi_bvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        chk("b_wait", {63'd0, axi_bvalid}, 64'd1);
        chk("bid", {56'd0, axi_bid}, {56'd0, id});
        chk("bresp", {62'd0, axi_bresp}, {62'd0, resp});
        @(posedge aclk);
        #1 axi_bready = 1'b0;
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [15:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n;
        @(negedge aclk);
        axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst;
        axi_arvalid = 1'b1;
        n = 0;
        while (axi_arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        chk("ar_wait", {63'd0, axi_arready}, 64'd1);
        @(posedge aclk);
        #1 axi_arvalid = 1'b0;
    endtask

    task automatic r_recv(input logic [31:0] data, input logic [7:0] id, input logic last);
        int n;
        @(negedge aclk);
        axi_rready = 1'b1;
        n = 0;
        while (axi_rvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        chk("r_wait", {63'd0, axi_rvalid}, 64'd1);
        chk("rdata", {32'd0, axi_rdata}, {32'd0, data});
        chk("rid", {56'd0, axi_rid}, {56'd0, id});
        chk("rlast", {63'd0, axi_rlast}, {63'd0, last});
        chk("rresp", {62'd0, axi_rresp}, 64'd0);
        @(posedge aclk);
        #1 axi_rready = 1'b0;
    endtask

    initial begin
        int n;
        areset = 1'b1;
        axi_awid = 8'd0; axi_awaddr = 16'd0; axi_awlen = 8'd0; axi_awsize = 3'd2;
        axi_awburst = 2'b01; axi_awvalid = 1'b0;
        axi_wdata = 32'd0; axi_wstrb = 4'd0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
        axi_bready = 1'b0;
        axi_arid = 8'd0; axi_araddr = 16'd0; axi_arlen = 8'd0; axi_arsize = 3'd2;
        axi_arburst = 2'b01; axi_arvalid = 1'b0;
        axi_rready = 1'b0;

        // Reset values
        repeat (3) @(negedge aclk);
        chk("reset_outs", all_outs(), 64'd0);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("awready_after_reset", {63'd0, axi_awready}, 64'd1);
        chk("arready_after_reset", {63'd0, axi_arready}, 64'd1);

        // Single write then read, with read latency
        aw_send(8'h05, 16'h0010, 8'd0, 2'b01);
        w_beat(32'hDEADBEEF, 4'hF, 1'b1);
        b_recv(8'h05, 2'b00);
        ar_send(8'h07, 16'h0010, 8'd0, 2'b01);
        chk("rvalid_fetch_cycle", {63'd0, axi_rvalid}, 64'd0);
        @(posedge aclk);
        #1;
        chk("rvalid_second_cycle", {63'd0, axi_rvalid}, 64'd1);
        r_recv(32'hDEADBEEF, 8'h07, 1'b1);

        // Partial strobe over 0xDEADBEEF
        aw_send(8'h01, 16'h0010, 8'd0, 2'b01);
        w_beat(32'h11223344, 4'h5, 1'b1);
        b_recv(8'h01, 2'b00);
        ar_send(8'h02, 16'h0010, 8'd0, 2'b01);
        r_recv(32'hDE22BE44, 8'h02, 1'b1);

        // INCR burst write, FIXED burst read
        aw_send(8'h02, 16'h0100, 8'd3, 2'b01);
        w_beat(32'd1, 4'hF, 1'b0);
        w_beat(32'd2, 4'hF, 1'b0);
        w_beat(32'd3, 4'hF, 1'b0);
        w_beat(32'd4, 4'hF, 1'b1);
        b_recv(8'h02, 2'b00);
        ar_send(8'h03, 16'h0100, 8'd1, 2'b00);
        r_recv(32'd1, 8'h03, 1'b0);
        r_recv(32'd1, 8'h03, 1'b1);

        // R backpressure: len=2 INCR read from 0x104, rready low for 5 cycles
        ar_send(8'h0A, 16'h0104, 8'd2, 2'b01);
        n = 0;
        while (axi_rvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("rhold_valid", {63'd0, axi_rvalid}, 64'd1);
            chk("rhold_data", {32'd0, axi_rdata}, 64'd2);
            chk("rhold_id", {56'd0, axi_rid}, 64'h0A);
            chk("rhold_last", {63'd0, axi_rlast}, 64'd0);
        end
        r_recv(32'd2, 8'h0A, 1'b0);
        r_recv(32'd3, 8'h0A, 1'b0);
        r_recv(32'd4, 8'h0A, 1'b1);
        @(negedge aclk);
        chk("rvalid_after_burst", {63'd0, axi_rvalid}, 64'd0);

        // B backpressure: bready low for 4 cycles
        aw_send(8'h09, 16'h0200, 8'd0, 2'b01);
        w_beat(32'hCAFEF00D, 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("bhold_valid", {63'd0, axi_bvalid}, 64'd1);
            chk("bhold_id", {56'd0, axi_bid}, 64'h09);
            chk("bhold_resp", {62'd0, axi_bresp}, 64'd0);
        end
        b_recv(8'h09, 2'b00);
        ar_send(8'h0D, 16'h0200, 8'd0, 2'b01);
        r_recv(32'hCAFEF00D, 8'h0D, 1'b1);

        // Early wlast on beat 1 of a len=2 burst
        aw_send(8'h04, 16'h0300, 8'd2, 2'b01);
        w_beat(32'h000000A0, 4'hF, 1'b0);
        w_beat(32'h000000B0, 4'hF, 1'b1);
        @(negedge aclk);
        chk("early_wlast_wready", {63'd0, axi_wready}, 64'd1);
        chk("early_wlast_bvalid", {63'd0, axi_bvalid}, 64'd0);
        w_beat(32'h000000C0, 4'hF, 1'b1);
        b_recv(8'h04, 2'b10);
        ar_send(8'h0B, 16'h0300, 8'd2, 2'b01);
        r_recv(32'h000000A0, 8'h0B, 1'b0);
        r_recv(32'h000000B0, 8'h0B, 1'b0);
        r_recv(32'h000000C0, 8'h0B, 1'b1);

        // Reset during beat 2 of a len=3 write
        aw_send(8'h06, 16'h0400, 8'd3, 2'b01);
        w_beat(32'h00000100, 4'hF, 1'b0);
        w_beat(32'h00000101, 4'hF, 1'b0);
        @(negedge aclk);
        axi_wdata = 32'h00000102; axi_wstrb = 4'hF; axi_wlast = 1'b0; axi_wvalid = 1'b1;
        areset = 1'b1;
        #1;
        chk("midreset_outs_async", all_outs(), 64'd0);
        @(posedge aclk);
        #1;
        chk("midreset_outs_held", all_outs(), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        axi_wvalid = 1'b0;
        axi_awid = 8'h08; axi_awaddr = 16'h0500; axi_awlen = 8'd0; axi_awburst = 2'b01;
        axi_awvalid = 1'b1;
        @(posedge aclk);
        #1;
        chk("release_awready", {63'd0, axi_awready}, 64'd1);
        chk("release_no_bvalid", {63'd0, axi_bvalid}, 64'd0);
        @(posedge aclk);
        #1;
        chk("release_aw_taken", {62'd0, axi_awready, axi_wready}, 64'd1);
        axi_awvalid = 1'b0;
        w_beat(32'h00000055, 4'hF, 1'b1);
        b_recv(8'h08, 2'b00);
        ar_send(8'h0C, 16'h0400, 8'd1, 2'b01);
        r_recv(32'h00000100, 8'h0C, 1'b0);
        r_recv(32'h00000101, 8'h0C, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
